// File: rtl/fifo_rd_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl_pkg
//  Purpose  : Shared constants and types for the FIFO read-arbitration control
//             unit: default address width, consumer identifiers and the
//             arbiter reset state.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_ctrl_pkg;

    localparam int DEFAULT_ADDRESS_SIZE = 2;

    // Consumer identifiers; also the encoding of the last-grant register.
    typedef enum logic [0:0] {
        CONS0 = 1'b0,
        CONS1 = 1'b1
    } cons_e;

    // Consumer 1 is recorded as the last winner so consumer 0 wins the first tie.
    localparam cons_e LAST_GNT_RST = CONS1;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_arb_ctrl_if
//  Purpose  : Handshake bundle between producer/consumers, the FIFO control
//             unit and the FIFO memory array.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_arb_ctrl_if #(
    parameter int ADDRESS_SIZE = fifo_ctrl_pkg::DEFAULT_ADDRESS_SIZE
);
    logic                    wr_req;
    logic [1:0]              rd_req;
    logic                    cw_en;
    logic                    cr_en;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic                    full;
    logic                    empty;
    logic [ADDRESS_SIZE:0]   count;
    logic [1:0]              rd_gnt;
    logic [1:0]              rd_valid;
    logic                    overflow;
    logic                    underflow;

    // Requesting side: producer and the two consumers.
    modport master (
        output wr_req, rd_req,
        input  cw_en, cr_en, w_addr, r_addr, full, empty, count,
               rd_gnt, rd_valid, overflow, underflow
    );

    // Control unit side.
    modport slave (
        input  wr_req, rd_req,
        output cw_en, cr_en, w_addr, r_addr, full, empty, count,
               rd_gnt, rd_valid, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arb_ctrl_ptr_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ptr_counter
//  Purpose  : Enable counter with synchronous active-low clear and natural
//             wrap; used for the FIFO write and read pointers (extra wrap bit
//             included in WIDTH).
//  Revision : 1.0 - initial release
// ============================================================================
module ptr_counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next pointer value; overflow past all-ones wraps to zero by width truncation.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Pointer register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_arb_ctrl
//  Purpose  : Control unit for a synchronous extra-bit FIFO. Owns the write and
//             read pointers, derives full/empty/count, gates the memory enables
//             and round-robin arbitrates the single read port between two
//             consumers. Memory read data arrives one cycle after cr_en.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arb_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int MEMORY_DEPTH = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    fifo_rd_arb_ctrl_if.slave bus
);
    localparam int PW = ADDRESS_SIZE + 1;

    // The extra-bit full/empty scheme only works for a power-of-two depth.
    if (MEMORY_DEPTH != (1 << ADDRESS_SIZE)) begin : g_depth_check
        $fatal(1, "fifo_rd_arb_ctrl: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
    end

    logic [PW-1:0] w_ptr_q;
    logic [PW-1:0] r_ptr_q;
    logic          full;
    logic          empty;
    logic          cw_en;
    logic          cr_en;
    logic [1:0]    rd_gnt;
    cons_e         last_gnt_q;
    logic [1:0]    rd_valid_q;
    logic          overflow_q;
    logic          underflow_q;

    ptr_counter #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (cw_en),
        .cnt_o (w_ptr_q)
    );

    ptr_counter #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (cr_en),
        .cnt_o (r_ptr_q)
    );

    // Flags straight from the registered pointers: same low bits with differing
    // wrap bits means the writer is one full lap ahead.
    assign full  = (w_ptr_q[PW-1] != r_ptr_q[PW-1]) &&
                   (w_ptr_q[PW-2:0] == r_ptr_q[PW-2:0]);
    assign empty = (w_ptr_q == r_ptr_q);

    // A refused request never touches memory or pointers.
    assign cw_en = bus.wr_req && !full;
    assign cr_en = (bus.rd_req != 2'b00) && !empty;

    // Round-robin grant: a tie goes to the consumer that did not win last time.
    always_comb begin
        rd_gnt = 2'b00;
        if (cr_en) begin
            case (bus.rd_req)
                2'b01:   rd_gnt = 2'b01;
                2'b10:   rd_gnt = 2'b10;
                2'b11:   rd_gnt = (last_gnt_q == CONS1) ? 2'b01 : 2'b10;
                default: rd_gnt = 2'b00;
            endcase
        end
    end

    // Arbiter state, read-data ownership pipeline and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q  <= LAST_GNT_RST;
            rd_valid_q  <= 2'b00;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (cr_en) begin
                last_gnt_q <= rd_gnt[1] ? CONS1 : CONS0;
            end
            rd_valid_q <= rd_gnt;
            if (bus.wr_req && full) begin
                overflow_q <= 1'b1;
            end
            if ((bus.rd_req != 2'b00) && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.cw_en     = cw_en;
    assign bus.cr_en     = cr_en;
    assign bus.w_addr    = w_ptr_q[PW-2:0];
    assign bus.r_addr    = r_ptr_q[PW-2:0];
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = w_ptr_q - r_ptr_q;
    assign bus.rd_gnt    = rd_gnt;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_arb_ctrl
//  Purpose  : Self-checking bench for fifo_rd_arb_ctrl: directed vector table,
//             a wrap-around sequence and randomized traffic against an
//             occupancy-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arb_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_arb_ctrl_if #(.ADDRESS_SIZE(AW)) bus ();

    fifo_rd_arb_ctrl #(
        .ADDRESS_SIZE (AW),
        .MEMORY_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: occupancy, total transfers, who won last, sticky flags.
    int         m_cnt;
    int         m_wr_tot;
    int         m_rd_tot;
    int         m_last;
    logic [1:0] m_valid;
    logic       m_ovf;
    logic       m_udf;
    logic       e_full, e_empty, e_cw, e_cr;
    logic [1:0] e_gnt;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [1:0] rd;
        int         cnt;
        logic       full;
        logic       empty;
        logic       cw;
        logic       cr;
        logic [1:0] gnt;
        logic [1:0] val;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] rq);
        @(negedge clk);
        rst_n      = r;
        bus.wr_req = w;
        bus.rd_req = rq;
        #1;
    endtask

    // Expected outputs for the current cycle from the model's occupancy view.
    task automatic model_check();
        e_full  = (m_cnt == DEPTH);
        e_empty = (m_cnt == 0);
        e_cw    = bus.wr_req && !e_full;
        e_cr    = (bus.rd_req != 2'b00) && !e_empty;
        if (!e_cr)                  e_gnt = 2'b00;
        else if (bus.rd_req == 2'b11) e_gnt = (m_last == 0) ? 2'b10 : 2'b01;
        else                        e_gnt = bus.rd_req;
        chk("count",     8'(bus.count),     8'(m_cnt));
        chk("full",      8'(bus.full),      8'(e_full));
        chk("empty",     8'(bus.empty),     8'(e_empty));
        chk("cw_en",     8'(bus.cw_en),     8'(e_cw));
        chk("cr_en",     8'(bus.cr_en),     8'(e_cr));
        chk("w_addr",    8'(bus.w_addr),    8'(m_wr_tot % DEPTH));
        chk("r_addr",    8'(bus.r_addr),    8'(m_rd_tot % DEPTH));
        chk("rd_gnt",    8'(bus.rd_gnt),    8'(e_gnt));
        chk("rd_valid",  8'(bus.rd_valid),  8'(m_valid));
        chk("overflow",  8'(bus.overflow),  8'(m_ovf));
        chk("underflow", 8'(bus.underflow), 8'(m_udf));
    endtask

    task automatic model_edge();
        @(posedge clk);
        if (!rst_n) begin
            m_cnt    = 0;
            m_wr_tot = 0;
            m_rd_tot = 0;
            m_last   = 1;
            m_valid  = 2'b00;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            if (e_cw) begin m_wr_tot++; m_cnt++; end
            if (e_cr) begin m_rd_tot++; m_cnt--; m_last = e_gnt[1] ? 1 : 0; end
            m_valid = e_gnt;
            if (bus.wr_req && e_full)             m_ovf = 1'b1;
            if ((bus.rd_req != 2'b00) && e_empty) m_udf = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [1:0] rq);
        drive(r, w, rq);
        model_check();
        model_edge();
    endtask

    initial begin
        //            rst   wr    rd     cnt full  empty cw    cr    gnt    val    ovf   udf
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'b00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'b00, 3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'b01, 4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'b11, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'b11, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'b11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'b11, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 2'b01, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 2'b01, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 2'b10, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 2'b11, 1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 2'b00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 2'b00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 2'b11, 2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};

        bus.wr_req = 1'b0;
        bus.rd_req = 2'b00;
        rst_n      = 1'b0;
        repeat (2) model_edge();

        // Directed vectors: fill, overflow, contention drain, underflow,
        // no read-through on empty, mid-run reset, post-reset arbitration.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].rd);
            chk($sformatf("v%0d.count", i), 8'(bus.count),     8'(tbl[i].cnt));
            chk($sformatf("v%0d.full", i),  8'(bus.full),      8'(tbl[i].full));
            chk($sformatf("v%0d.empty", i), 8'(bus.empty),     8'(tbl[i].empty));
            chk($sformatf("v%0d.cw", i),    8'(bus.cw_en),     8'(tbl[i].cw));
            chk($sformatf("v%0d.cr", i),    8'(bus.cr_en),     8'(tbl[i].cr));
            chk($sformatf("v%0d.gnt", i),   8'(bus.rd_gnt),    8'(tbl[i].gnt));
            chk($sformatf("v%0d.valid", i), 8'(bus.rd_valid),  8'(tbl[i].val));
            chk($sformatf("v%0d.ovf", i),   8'(bus.overflow),  8'(tbl[i].ovf));
            chk($sformatf("v%0d.udf", i),   8'(bus.underflow), 8'(tbl[i].udf));
            model_check();
            model_edge();
        end

        // Wrap-around: six write/read pairs from reset leave both pointers at 6.
        step(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 2'b00);
            step(1'b1, 1'b0, 2'b10);
        end
        drive(1'b1, 1'b0, 2'b00);
        chk("wrap.w_addr", 8'(bus.w_addr), 8'd2);
        chk("wrap.r_addr", 8'(bus.r_addr), 8'd2);
        chk("wrap.count",  8'(bus.count),  8'd0);
        chk("wrap.empty",  8'(bus.empty),  8'd1);
        chk("wrap.full",   8'(bus.full),   8'd0);
        model_check();
        model_edge();

        // Simultaneous write and read at count 2.
        step(1'b1, 1'b1, 2'b00);
        step(1'b1, 1'b1, 2'b00);
        drive(1'b1, 1'b1, 2'b01);
        chk("simul.cw",    8'(bus.cw_en), 8'd1);
        chk("simul.cr",    8'(bus.cr_en), 8'd1);
        model_check();
        model_edge();
        drive(1'b1, 1'b0, 2'b00);
        chk("simul.count", 8'(bus.count), 8'd2);
        model_check();
        model_edge();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       w;
            logic [1:0] rq;
            r  = ($urandom_range(0, 99) != 0);
            w  = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 30));
            rq = 2'($urandom_range(0, 3));
            step(r, w, rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
